seq_alu: RTL and testbench

//  Parametrised, multi-cycle successor to the combinational datapath ALU, sitting between the Y/B operand registers and the C (HI/LO/Z) register.

---
 rtl/seq_alu.sv | 216 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU. Single-cycle logic/shift/add ops, radix-2
//               Booth multiply and signed restoring divide behind a
//               start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   Y_in,
  input  logic [WIDTH-1:0]   B_in,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] C_out
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [4:0] OP_SHL  = 5'b11011;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MUL_IT = 2'd1;
  localparam logic [1:0] S_DIV_IT = 2'd2;
  localparam logic [1:0] S_FIX    = 2'd3;

  localparam logic [SHW-1:0] c_last_iter = SHW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH:0]   r_acc;      // Booth accumulator / divide remainder (one guard bit)
  logic [WIDTH-1:0] r_q;        // multiplier / quotient shift register
  logic             r_q_m1;     // Booth q(-1) bit
  logic [WIDTH:0]   r_mcand;    // sign-extended multiplicand or zero-extended |divisor|
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_b_zero;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_alu;
  logic             w_keep;
  logic [WIDTH-1:0] w_y_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_accept = start && !busy;
  assign w_b_zero = (B_in == '0);
  assign w_amt    = B_in[SHW-1:0];
  assign w_y_abs  = Y_in[WIDTH-1] ? -Y_in : Y_in;
  assign w_b_abs  = B_in[WIDTH-1] ? -B_in : B_in;

  // State register
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (opcode == OP_MUL)                  w_next_state = S_MUL_IT;
          else if (opcode == OP_DIV && !w_b_zero) w_next_state = S_DIV_IT;
        end
      end
      S_MUL_IT, S_DIV_IT: if (r_cnt == c_last_iter) w_next_state = S_FIX;
      default:            w_next_state = S_IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Single-cycle result
  always_comb begin
    w_alu  = '0;
    w_keep = 1'b0;
    case (opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: w_alu = Y_in + B_in;
      OP_SUB:           w_alu = Y_in - B_in;
      OP_SHR:           w_alu = Y_in >> w_amt;
      OP_SHRA:          w_alu = $signed(Y_in) >>> w_amt;
      OP_SHL:           w_alu = Y_in << w_amt;
      OP_ROR:           w_alu = (Y_in >> w_amt) | (Y_in << (WIDTH - int'(w_amt)));
      OP_ROL:           w_alu = (Y_in << w_amt) | (Y_in >> (WIDTH - int'(w_amt)));
      OP_AND, OP_ANDI:  w_alu = Y_in & B_in;
      OP_OR, OP_ORI:    w_alu = Y_in | B_in;
      OP_NEG:           w_alu = -B_in;
      OP_NOT:           w_alu = ~B_in;
      OP_BR, OP_NOP, OP_HALT: w_keep = 1'b1;
      default:          w_alu = '0;
    endcase
  end

  // Iteration datapath
  always_comb begin
    case ({r_q[0], r_q_m1})
      2'b01:   w_booth_sum = r_acc + r_mcand;
      2'b10:   w_booth_sum = r_acc - r_mcand;
      default: w_booth_sum = r_acc;
    endcase
    w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_div_diff  = w_div_shift - r_mcand;
    w_quot      = r_neg_q ? -r_q : r_q;
    w_rem       = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      C_out    <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_q_m1   <= 1'b0;
      r_mcand  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_acc <= '0;
            if (opcode == OP_MUL) begin
              r_q      <= Y_in;
              r_q_m1   <= 1'b0;
              r_mcand  <= {B_in[WIDTH-1], B_in};
              r_is_div <= 1'b0;
            end else if (opcode == OP_DIV && !w_b_zero) begin
              r_q      <= w_y_abs;
              r_mcand  <= {1'b0, w_b_abs};
              r_is_div <= 1'b1;
              r_neg_q  <= Y_in[WIDTH-1] ^ B_in[WIDTH-1];
              r_neg_r  <= Y_in[WIDTH-1];
            end else if (opcode == OP_DIV) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              C_out    <= {Y_in, {WIDTH{1'b1}}};
            end else begin
              done     <= 1'b1;
              div_zero <= 1'b0;
              if (!w_keep) C_out <= {{WIDTH{1'b0}}, w_alu};
            end
          end
        end
        S_MUL_IT: begin
          r_acc  <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
          r_q    <= {w_booth_sum[0], r_q[WIDTH-1:1]};
          r_q_m1 <= r_q[0];
          r_cnt  <= r_cnt + 1'b1;
        end
        S_DIV_IT: begin
          if (!w_div_diff[WIDTH]) begin
            r_acc <= w_div_diff;
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_div_shift;
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          done     <= 1'b1;
          div_zero <= 1'b0;
          if (r_is_div) C_out <= {w_rem, w_quot};
          else          C_out <= {r_acc[WIDTH-1:0], r_q};
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking bench for seq_alu (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

  localparam int W = 32;

  logic         clk;
  logic         clr;
  logic         start;
  logic [4:0]   opcode;
  logic [W-1:0] Y_in;
  logic [W-1:0] B_in;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [2*W-1:0] C_out;

  int n_checks = 0;
  int n_errors = 0;
  int lat, bcyc, unstable;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode),
    .Y_in(Y_in), .B_in(B_in), .busy(busy), .done(done),
    .div_zero(div_zero), .C_out(C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] y, input logic [W-1:0] b);
    start = 1'b1; opcode = op; Y_in = y; B_in = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen.
  task automatic wait_done(output int l, output int bc, output int unst);
    logic [2*W-1:0] prev;
    prev = C_out; l = 0; bc = 0; unst = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      if (C_out !== prev) unst++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run_single(input string tag, input logic [4:0] op,
                            input logic [W-1:0] y, input logic [W-1:0] b,
                            input logic [63:0] exp);
    issue(op, y, b);
    wait_done(lat, bcyc, unstable);
    check_eq({tag, "_lat"}, 64'(lat), 64'd0);
    check_eq(tag, C_out, exp);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; opcode = '0; Y_in = '0; B_in = '0;
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dz",   64'(div_zero), 64'd0);
    check_eq("rst_cout", C_out, 64'd0);
    clr = 1'b0;

    run_single("add", 5'b00011, 32'd5, 32'd3, 64'h0000_0000_0000_0008);
    run_single("add_wrap", 5'b00011, 32'hFFFF_FFFF, 32'd1, 64'h0);
    @(posedge clk); #1;
    check_eq("done_pulse", 64'(done), 64'd0);

    // MUL -7 * 6
    issue(5'b01110, 32'hFFFF_FFF9, 32'd6);
    wait_done(lat, bcyc, unstable);
    check_eq("mul_lat",  64'(lat), 64'd33);
    check_eq("mul_busy", 64'(bcyc), 64'd33);
    check_eq("mul_stable", 64'(unstable), 64'd0);
    check_eq("mul_res",  C_out, 64'hFFFF_FFFF_FFFF_FFD6);
    check_eq("mul_busy_at_done", 64'(busy), 64'd0);
    // back-to-back: issued in the done cycle
    issue(5'b01110, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bcyc, unstable);
    check_eq("mul_min_lat", 64'(lat), 64'd33);
    check_eq("mul_min", C_out, 64'h4000_0000_0000_0000);

    // DIV -17 / 5
    issue(5'b01111, 32'hFFFF_FFEF, 32'd5);
    wait_done(lat, bcyc, unstable);
    check_eq("div_lat", 64'(lat), 64'd33);
    check_eq("div_res", C_out, 64'hFFFF_FFFE_FFFF_FFFD);
    check_eq("div_dz",  64'(div_zero), 64'd0);
    issue(5'b01111, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bcyc, unstable);
    check_eq("div_min_m1", C_out, 64'h0000_0000_8000_0000);
    issue(5'b01111, 32'd100, 32'hFFFF_FFF9);
    wait_done(lat, bcyc, unstable);
    check_eq("div_pos_neg", C_out, 64'h0000_0002_FFFF_FFF2);

    // DIV by zero
    issue(5'b01111, 32'd100, 32'd0);
    wait_done(lat, bcyc, unstable);
    check_eq("dz_lat", 64'(lat), 64'd0);
    check_eq("dz_flag", 64'(div_zero), 64'd1);
    check_eq("dz_res", C_out, 64'h0000_0064_FFFF_FFFF);
    run_single("add_after_dz", 5'b00011, 32'd2, 32'd3, 64'h5);
    check_eq("dz_cleared", 64'(div_zero), 64'd0);

    // MUL 3*5 with ignored ADD re-pulse at +5
    issue(5'b01110, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; opcode = 5'b00011; Y_in = 32'd100; B_in = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcyc, unstable);
    check_eq("repulse_lat", 64'(lat), 64'd28);
    check_eq("repulse_res", C_out, 64'hF);
    @(posedge clk); #1;
    check_eq("repulse_no_2nd", 64'(done | busy), 64'd0);

    // Abort: clr at +10
    issue(5'b01110, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_cout", C_out, 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    wait_done(lat, bcyc, unstable);
    check_eq("abort_no_done", 64'(lat), 64'd100);

    // Shifts, rotates and logic
    run_single("shra", 5'b00110, 32'h8000_0000, 32'd4,  64'hF800_0000);
    run_single("shl",  5'b11011, 32'h0000_0001, 32'd31, 64'h8000_0000);
    run_single("rol",  5'b01000, 32'h8000_0001, 32'd1,  64'h0000_0003);
    run_single("shr_hi_b", 5'b00101, 32'h0000_00F0, 32'h24, 64'h0000_000F);
    run_single("ror",  5'b00111, 32'h0000_0001, 32'd1,  64'h8000_0000);
    run_single("shra_0", 5'b00110, 32'h8000_0010, 32'd0, 64'h8000_0010);
    run_single("sub",  5'b00100, 32'd3, 32'd5, 64'hFFFF_FFFE);
    run_single("neg",  5'b10000, 32'd0, 32'd5, 64'hFFFF_FFFB);
    run_single("not",  5'b10001, 32'd0, 32'h0F0F_0F0F, 64'hF0F0_F0F0);
    run_single("and",  5'b01001, 32'hFF00_FF00, 32'h0F0F_0F0F, 64'h0F00_0F00);
    run_single("or",   5'b01010, 32'hFF00_FF00, 32'h0F0F_0F0F, 64'hFF0F_FF0F);
    run_single("nop_keep", 5'b11001, 32'd1, 32'd1, 64'hFF0F_FF0F);
    run_single("illegal", 5'b11111, 32'd1, 32'd1, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
